// File: rtl/clk_div_mux_pkg.sv
// Shared types and helpers for the glitch-free divided-clock selector.
package clk_div_mux_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int SW_CNT_W = 16;

  // A programmed half-period of zero is treated as one cycle.
  function automatic int unsigned half_per(input int unsigned div);
    return (div == 0) ? 32'd1 : div;
  endfunction

endpackage

// File: rtl/clk_div_mux_ctr.sv
// Half-period counter: tick fires once cnt reaches h-1 and cnt restarts from zero.
module clk_div_mux_ctr #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] h,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;

  // h is compared live with >=, so a shrinking h never makes cnt wrap around.
  assign tick = run && (cnt >= (h - DIV_W'(1)));

  always_ff @(posedge clk_i) begin
    if (clear)    cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + DIV_W'(1);
  end

endmodule

// File: rtl/clk_div_mux.sv
// Glitch-free selector of NUM_CH divided clocks with an all-off gap between channels.
// Optional switch counter output sw_cnt_o is built when CLK_DIV_MUX_SWITCH_CNT_EN is defined.
module clk_div_mux
  import clk_div_mux_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DIV_W      = 8,
  parameter  int GAP_CYCLES = 2,
  localparam int SEL_W      = $clog2(NUM_CH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [SEL_W-1:0]        sel_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic                    clk_o,
  output logic [NUM_CH-1:0]       en_o,
  output logic                    busy_o
`ifdef CLK_DIV_MUX_SWITCH_CNT_EN
  ,
  output logic [SW_CNT_W-1:0]     sw_cnt_o
`endif
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e                         state_q, state_d;
  logic [NUM_CH-1:0][DIV_W-1:0]   div_arr;
  logic [SEL_W-1:0]               cur_sel, sel_d;
  logic [GW-1:0]                  gap_cnt;
  logic                           clk_d;
  logic [NUM_CH-1:0]              en_d;
  logic [DIV_W-1:0]               h;
  logic                           ctr_run, ctr_clr, tick;
  logic                           sel_ok, req, gap_last;

  assign div_arr  = div_i;
  assign h        = DIV_W'(half_per(32'(div_arr[cur_sel])));
  assign sel_ok   = int'(sel_i) < NUM_CH;
  assign req      = sel_ok && (sel_i != cur_sel);
  assign gap_last = (gap_cnt == GW'(GAP_CYCLES - 1));
  assign ctr_run  = (state_q != GAP);
  assign busy_o   = (state_q != RUN);

  clk_div_mux_ctr #(.DIV_W(DIV_W)) u_ctr (
    .clk_i (clk_i),
    .run   (ctr_run),
    .clear (rst_i | ctr_clr),
    .h     (h),
    .tick  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= RUN;
    else       state_q <= state_d;
  end

  // A request during a high phase that is not ending this cycle must drain it first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (req)      state_d = (clk_o && !tick) ? DRAIN : GAP;
      DRAIN:   if (tick)     state_d = GAP;
      GAP:     if (gap_last) state_d = RUN;
      default:               state_d = RUN;
    endcase
  end

  always_comb begin
    clk_d   = clk_o;
    en_d    = en_o;
    sel_d   = cur_sel;
    ctr_clr = 1'b0;
    case (state_q)
      RUN: begin
        if (tick) clk_d = ~clk_o;
        if (req && (!clk_o || tick)) begin
          clk_d   = 1'b0;
          en_d    = '0;
          ctr_clr = 1'b1;
        end
      end
      DRAIN: begin
        if (tick) begin
          clk_d = 1'b0;
          en_d  = '0;
        end
      end
      GAP: begin
        clk_d   = 1'b0;
        en_d    = '0;
        ctr_clr = 1'b1;
        // Only the selection present at the end of the gap is honoured.
        if (gap_last) begin
          if (sel_ok) sel_d = sel_i;
          en_d = NUM_CH'(1) << sel_d;
        end
      end
      default: begin
        clk_d   = 1'b0;
        ctr_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_o   <= 1'b0;
      en_o    <= NUM_CH'(1);
      cur_sel <= '0;
      gap_cnt <= '0;
    end else begin
      clk_o   <= clk_d;
      en_o    <= en_d;
      cur_sel <= sel_d;
      gap_cnt <= (state_q == GAP && !gap_last) ? gap_cnt + GW'(1) : '0;
    end
  end

`ifdef CLK_DIV_MUX_SWITCH_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i)                          sw_cnt_o <= '0;
    else if (state_q == GAP && gap_last) sw_cnt_o <= sw_cnt_o + SW_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_clk_div_mux.sv
// Directed and random checks of clk_div_mux against a timestamp-based reference model.
module tb_clk_div_mux;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;
  localparam int GAP    = 2;

  logic                         clk_i;
  logic                         rst_i;
  logic [1:0]                   sel_i;
  logic [NUM_CH-1:0][DIV_W-1:0] div_i;
  logic                         clk_o;
  logic [NUM_CH-1:0]            en_o;
  logic                         busy_o;
`ifdef CLK_DIV_MUX_SWITCH_CNT_EN
  logic [15:0]                  sw_cnt_o;
`endif

  clk_div_mux #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .GAP_CYCLES(GAP)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sel_i  (sel_i),
    .div_i  (div_i),
    .clk_o  (clk_o),
    .en_o   (en_o),
    .busy_o (busy_o)
`ifdef CLK_DIV_MUX_SWITCH_CNT_EN
    ,
    .sw_cnt_o (sw_cnt_o)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: edge counter plus timestamps of the last phase start and gap end.
  int          t = 0;
  int          m_ps = 0;
  int          m_gap_end = -1;
  bit          m_drain = 0;
  bit          m_clk = 0;
  bit          m_busy = 0;
  logic [3:0]  m_en = 4'b0001;
  int          m_sel = 0;
  int          m_sw = 0;

  function automatic int hper(input logic [7:0] d);
    return (d == 8'd0) ? 1 : int'(d);
  endfunction

  task automatic model_edge();
    int  h;
    int  s;
    bit  req;
    t++;
    s = int'(sel_i);
    h = hper(div_i[m_sel]);
    if (rst_i) begin
      m_clk = 0; m_en = 4'b0001; m_busy = 0; m_sel = 0;
      m_ps = t; m_gap_end = -1; m_drain = 0; m_sw = 0;
      return;
    end
    req = (s < NUM_CH) && (s != m_sel);
    if (m_gap_end >= 0) begin
      if (t == m_gap_end) begin
        if (s < NUM_CH) m_sel = s;
        m_en = 4'b0001 << m_sel;
        m_busy = 0; m_ps = t; m_gap_end = -1; m_sw++;
      end
    end else if (m_drain) begin
      if (t - m_ps >= h) begin
        m_clk = 0; m_en = 4'b0000; m_drain = 0; m_gap_end = t + GAP;
      end
    end else if (req) begin
      m_busy = 1;
      if (m_clk && (t - m_ps < h)) m_drain = 1;
      else begin
        m_clk = 0; m_en = 4'b0000; m_gap_end = t + GAP;
      end
    end else if (t - m_ps >= h) begin
      m_clk = ~m_clk; m_ps = t;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at edge %0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    #1;
    chk("clk_o",   32'(clk_o),   32'(m_clk));
    chk("en_o",    32'(en_o),    32'(m_en));
    chk("busy_o",  32'(busy_o),  32'(m_busy));
    chk("onehot0", 32'($onehot0(en_o)), 32'd1);
`ifdef CLK_DIV_MUX_SWITCH_CNT_EN
    chk("sw_cnt_o", 32'(sw_cnt_o), 32'(m_sw[15:0]));
`endif
  endtask

  task automatic wait_clk(input bit v);
    int k;
    k = 0;
    while (m_clk != v && k < 60) begin step(); k++; end
    n_vec++;
    assert (m_clk == v) else begin
      n_err++;
      $error("FAIL wait_clk timeout: got %0d expected %0d", m_clk, v);
    end
  endtask

  task automatic wait_idle(input int target);
    int k;
    k = 0;
    while ((m_busy || m_sel != target) && k < 100) begin step(); k++; end
    chk("switch_done", 32'(busy_o), 32'd0);
    chk("switch_en", 32'(en_o), 32'(4'b0001 << target));
  endtask

  initial begin
    rst_i = 1'b1;
    sel_i = 2'd0;
    div_i = {8'd5, 8'd3, 8'd2, 8'd0};

    // 1: reset held 3 cycles, then ch0 at period 2
    repeat (3) step();
    chk("rst_clk",  32'(clk_o),  32'd0);
    chk("rst_en",   32'(en_o),   32'b0001);
    chk("rst_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    repeat (8) step();

    // 2: switch to ch2 while clk_o low
    wait_clk(1'b0);
    sel_i = 2'd2;
    step();
    chk("t2_busy1", 32'(busy_o), 32'd1);
    chk("t2_en0",   32'(en_o),   32'd0);
    step();
    chk("t2_busy2", 32'(busy_o), 32'd1);
    step();
    chk("t2_en",    32'(en_o),   32'b0100);
    chk("t2_idle",  32'(busy_o), 32'd0);
    repeat (2) begin step(); chk("t2_low", 32'(clk_o), 32'd0); end
    step();
    chk("t2_rise", 32'(clk_o), 32'd1);
    repeat (14) step();

    // 3: switch to ch3 one cycle after a rising edge on ch2
    wait_clk(1'b0);
    wait_clk(1'b1);
    step();
    sel_i = 2'd3;
    step();
    chk("t3_drain_en", 32'(en_o), 32'b0100);
    chk("t3_drain_hi", 32'(clk_o), 32'd1);
    wait_idle(3);
    repeat (22) step();

    // 4: sel_i toggling every cycle through the switch
    for (int i = 0; i < 20; i++) begin
      sel_i = (i % 2 == 0) ? 2'd1 : 2'd3;
      step();
    end
    sel_i = 2'd3;
    repeat (20) step();

    // 5: one-cycle reset pulse inside GAP
    sel_i = 2'd1;
    begin
      int k;
      k = 0;
      while (m_gap_end < 0 && k < 60) begin step(); k++; end
    end
    rst_i = 1'b1;
    step();
    chk("t5_clk",  32'(clk_o),  32'd0);
    chk("t5_en",   32'(en_o),   32'b0001);
    chk("t5_busy", 32'(busy_o), 32'd0);
    rst_i = 1'b0;
    sel_i = 2'd0;
    repeat (10) step();
    chk("t5_noX", 32'($isunknown({clk_o, en_o, busy_o})), 32'd0);

`ifdef CLK_DIV_MUX_SWITCH_CNT_EN
    // 6: five switches then a same-channel request
    for (int i = 0; i < 5; i++) begin
      sel_i = 2'((i % 3) + 1);
      wait_idle((i % 3) + 1);
    end
    chk("t6_cnt5", 32'(sw_cnt_o), 32'd5);
    sel_i = 2'd2;
    repeat (6) begin step(); chk("t6_nobusy", 32'(busy_o), 32'd0); end
    chk("t6_cnt_hold", 32'(sw_cnt_o), 32'd5);
`endif

    // Random phase: live div changes, random selections and occasional resets
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) sel_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) div_i[$urandom_range(0, 3)] = 8'($urandom_range(0, 6));
      rst_i = ($urandom_range(0, 299) == 0);
      step();
    end
    rst_i = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
